// File: rtl/mem_port_arbiter.sv
// Shares the single main-memory block port between the I-cache and D-cache.
// Tie-break policy: define ARB_ROUND_ROBIN_EN for round robin, otherwise D has fixed priority.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 28,
  parameter int BLOCK_WIDTH = 128
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   I_READ,
  input  logic [ADDR_WIDTH-1:0]  I_ADDRESS,
  output logic [BLOCK_WIDTH-1:0] I_READDATA,
  output logic                   I_BUSYWAIT,
  input  logic                   D_READ,
  input  logic                   D_WRITE,
  input  logic [ADDR_WIDTH-1:0]  D_ADDRESS,
  input  logic [BLOCK_WIDTH-1:0] D_WRITEDATA,
  output logic [BLOCK_WIDTH-1:0] D_READDATA,
  output logic                   D_BUSYWAIT,
  output logic                   MEM_READ,
  output logic                   MEM_WRITE,
  output logic [ADDR_WIDTH-1:0]  MEM_ADDRESS,
  output logic [BLOCK_WIDTH-1:0] MEM_WRITEDATA,
  input  logic [BLOCK_WIDTH-1:0] MEM_READDATA,
  input  logic                   MEM_BUSYWAIT
);

  typedef enum logic [2:0] {IDLE, GRANT_I, GRANT_D, DONE_I, DONE_D} state_t;

  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

  state_t                 state_q;
  logic                   last_grant_q;
  logic                   mem_read_q;
  logic                   mem_write_q;
  logic [ADDR_WIDTH-1:0]  mem_addr_q;
  logic [BLOCK_WIDTH-1:0] mem_wdata_q;
  logic [BLOCK_WIDTH-1:0] i_rdata_q;
  logic [BLOCK_WIDTH-1:0] d_rdata_q;

  logic i_req;
  logic d_req;
  logic d_wins_tie;

  assign i_req = I_READ;
  assign d_req = D_READ | D_WRITE;

`ifdef ARB_ROUND_ROBIN_EN
  assign d_wins_tie = (last_grant_q == LAST_I);
`else
  // Last-grant history is still tracked but can never change the outcome here.
  assign d_wins_tie = last_grant_q | 1'b1;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_I;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (d_req && (!i_req || d_wins_tie)) begin
            // A simultaneous read and write-back resolves to the write-back.
            state_q     <= GRANT_D;
            mem_read_q  <= ~D_WRITE;
            mem_write_q <= D_WRITE;
            mem_addr_q  <= D_ADDRESS;
            mem_wdata_q <= D_WRITE ? D_WRITEDATA : '0;
          end else if (i_req) begin
            state_q     <= GRANT_I;
            mem_read_q  <= 1'b1;
            mem_write_q <= 1'b0;
            mem_addr_q  <= I_ADDRESS;
            mem_wdata_q <= '0;
          end
        end
        GRANT_I: begin
          if (!MEM_BUSYWAIT) begin
            state_q      <= DONE_I;
            i_rdata_q    <= MEM_READDATA;
            last_grant_q <= LAST_I;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
          end
        end
        GRANT_D: begin
          if (!MEM_BUSYWAIT) begin
            state_q      <= DONE_D;
            d_rdata_q    <= MEM_READDATA;
            last_grant_q <= LAST_D;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
          end
        end
        DONE_I, DONE_D: state_q <= IDLE;
        default:        state_q <= IDLE;
      endcase
    end
  end

  // NOTE: defaults first so no path through the case leaves an output
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    I_BUSYWAIT = i_req;
    D_BUSYWAIT = d_req;
    case (state_q)
      GRANT_I: I_BUSYWAIT = 1'b1;
      GRANT_D: D_BUSYWAIT = 1'b1;
      DONE_I:  I_BUSYWAIT = 1'b0;
      DONE_D:  D_BUSYWAIT = 1'b0;
      default: ;
    endcase
  end

  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = mem_addr_q;
  assign MEM_WRITEDATA = mem_wdata_q;
  assign I_READDATA    = i_rdata_q;
  assign D_READDATA    = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a variable-latency memory model.
module tb_mem_port_arbiter;
  localparam int AW = 28;
  localparam int BW = 128;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          I_READ;
  logic [AW-1:0] I_ADDRESS;
  logic [BW-1:0] I_READDATA;
  logic          I_BUSYWAIT;
  logic          D_READ;
  logic          D_WRITE;
  logic [AW-1:0] D_ADDRESS;
  logic [BW-1:0] D_WRITEDATA;
  logic [BW-1:0] D_READDATA;
  logic          D_BUSYWAIT;
  logic          MEM_READ;
  logic          MEM_WRITE;
  logic [AW-1:0] MEM_ADDRESS;
  logic [BW-1:0] MEM_WRITEDATA;
  logic [BW-1:0] MEM_READDATA;
  logic          MEM_BUSYWAIT;

  int checks   = 0;
  int failures = 0;
  int mem_lat  = 1;
  int mem_cnt  = 0;

  mem_port_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
    .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  // Memory stays busy for mem_lat-1 cycles of an active strobe, then completes.
  always @(posedge CLK) mem_cnt <= (MEM_READ || MEM_WRITE) ? mem_cnt + 1 : 0;
  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mem_cnt != mem_lat - 1);

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_low(input bit use_d, input int budget, output int n);
    n = -1;
    for (int k = 1; k <= budget; k++) begin
      tick();
      if ((use_d ? D_BUSYWAIT : I_BUSYWAIT) === 1'b0) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    I_READ = 1'b0; D_READ = 1'b0; D_WRITE = 1'b0;
    I_ADDRESS = '0; D_ADDRESS = '0; D_WRITEDATA = '0; MEM_READDATA = '0;
    repeat (2) tick();
    D_READ = 1'b1;
    #1;
    checks++; if (D_BUSYWAIT !== 1'b1) begin failures++; $display("FAIL rst_d_busy_follows: got %0h want 1", D_BUSYWAIT); end
    checks++; if (I_BUSYWAIT !== 1'b0) begin failures++; $display("FAIL rst_i_busy_follows: got %0h want 0", I_BUSYWAIT); end
    checks++; if ({MEM_READ, MEM_WRITE} !== 2'b00) begin failures++; $display("FAIL rst_strobes: got %0h want 0", {MEM_READ, MEM_WRITE}); end
    checks++; if (MEM_ADDRESS !== '0) begin failures++; $display("FAIL rst_mem_addr: got %0h want 0", MEM_ADDRESS); end
    checks++; if (MEM_WRITEDATA !== '0) begin failures++; $display("FAIL rst_mem_wdata: got %0h want 0", MEM_WRITEDATA); end
    checks++; if (I_READDATA !== '0 || D_READDATA !== '0) begin failures++; $display("FAIL rst_readdata: got %0h/%0h want 0/0", I_READDATA, D_READDATA); end
    D_READ = 1'b0;
    tick();
    RESET = 1'b0;
    tick();
    checks++; if (D_BUSYWAIT !== 1'b0 || MEM_READ !== 1'b0) begin failures++; $display("FAIL rst_idle_after: got busy=%0h rd=%0h want 0/0", D_BUSYWAIT, MEM_READ); end
  endtask

  task automatic test_i_read_latency();
    logic [BW-1:0] blk;
    int rd_cycles;
    int done_at;
    blk = 128'hDEADBEEF_01234567_89ABCDEF_00001111;
    mem_lat = 5;
    MEM_READDATA = blk;
    I_ADDRESS = 28'h0000010;
    I_READ = 1'b1;
    #1;
    checks++; if (I_BUSYWAIT !== 1'b1) begin failures++; $display("FAIL iread_pending: got %0h want 1", I_BUSYWAIT); end
    tick();
    checks++; if (MEM_READ !== 1'b1 || MEM_WRITE !== 1'b0) begin failures++; $display("FAIL iread_strobe: got rd=%0h wr=%0h want 1/0", MEM_READ, MEM_WRITE); end
    checks++; if (MEM_ADDRESS !== 28'h0000010) begin failures++; $display("FAIL iread_addr: got %0h want 10", MEM_ADDRESS); end
    checks++; if (MEM_WRITEDATA !== '0) begin failures++; $display("FAIL iread_wdata: got %0h want 0", MEM_WRITEDATA); end
    rd_cycles = (MEM_READ === 1'b1) ? 1 : 0;
    done_at = -1;
    for (int k = 2; k <= 20; k++) begin
      tick();
      if (MEM_READ === 1'b1) rd_cycles++;
      if (I_BUSYWAIT === 1'b0) begin
        done_at = k;
        break;
      end
    end
    checks++; if (rd_cycles !== 5) begin failures++; $display("FAIL iread_strobe_len: got %0d want 5", rd_cycles); end
    checks++; if (done_at !== 6) begin failures++; $display("FAIL iread_done_cycle: got %0d want 6", done_at); end
    checks++; if (I_READDATA !== blk) begin failures++; $display("FAIL iread_data: got %0h want %0h", I_READDATA, blk); end
    tick();
    checks++; if (I_BUSYWAIT !== 1'b1 || MEM_READ !== 1'b0) begin failures++; $display("FAIL iread_done_one_cycle: got busy=%0h rd=%0h want 1/0", I_BUSYWAIT, MEM_READ); end
    I_READ = 1'b0;
    tick();
    checks++; if (I_BUSYWAIT !== 1'b0 || MEM_READ !== 1'b0) begin failures++; $display("FAIL iread_idle: got busy=%0h rd=%0h want 0/0", I_BUSYWAIT, MEM_READ); end
    checks++; if (I_READDATA !== blk) begin failures++; $display("FAIL iread_data_hold: got %0h want %0h", I_READDATA, blk); end
  endtask

  task automatic test_d_write_wins();
    logic [BW-1:0] wd;
    int n;
    wd = 128'hCAFEF00D_11223344_55667788_99AABBCC;
    mem_lat = 3;
    MEM_READDATA = 128'h5;
    D_ADDRESS = 28'h0000020;
    D_WRITEDATA = wd;
    D_READ = 1'b1;
    D_WRITE = 1'b1;
    tick();
    checks++; if (MEM_WRITE !== 1'b1 || MEM_READ !== 1'b0) begin failures++; $display("FAIL dwr_strobes: got wr=%0h rd=%0h want 1/0", MEM_WRITE, MEM_READ); end
    checks++; if (MEM_ADDRESS !== 28'h0000020) begin failures++; $display("FAIL dwr_addr: got %0h want 20", MEM_ADDRESS); end
    checks++; if (MEM_WRITEDATA !== wd) begin failures++; $display("FAIL dwr_wdata: got %0h want %0h", MEM_WRITEDATA, wd); end
    checks++; if (D_BUSYWAIT !== 1'b1 || I_BUSYWAIT !== 1'b0) begin failures++; $display("FAIL dwr_busy: got d=%0h i=%0h want 1/0", D_BUSYWAIT, I_BUSYWAIT); end
    wait_low(1'b1, 12, n);
    checks++; if (n !== 3) begin failures++; $display("FAIL dwr_latency: got %0d want 3", n); end
    D_READ = 1'b0;
    D_WRITE = 1'b0;
    tick();
  endtask

  task automatic test_withdraw();
    logic [BW-1:0] blk;
    int n;
    blk = 128'h0BADC0DE_0BADC0DE_12345678_9ABCDEF0;
    mem_lat = 4;
    MEM_READDATA = blk;
    I_ADDRESS = 28'h0000030;
    I_READ = 1'b1;
    tick();
    tick();
    I_READ = 1'b0;
    #1;
    checks++; if (I_BUSYWAIT !== 1'b1 || MEM_READ !== 1'b1) begin failures++; $display("FAIL wd_mid_grant: got busy=%0h rd=%0h want 1/1", I_BUSYWAIT, MEM_READ); end
    wait_low(1'b0, 12, n);
    checks++; if (n !== 3) begin failures++; $display("FAIL wd_done_cycle: got %0d want 3", n); end
    checks++; if (I_READDATA !== blk) begin failures++; $display("FAIL wd_data: got %0h want %0h", I_READDATA, blk); end
    tick();
    checks++; if ({MEM_READ, MEM_WRITE} !== 2'b00 || MEM_ADDRESS !== '0) begin failures++; $display("FAIL wd_idle_quiet: got strobes=%0h addr=%0h want 0/0", {MEM_READ, MEM_WRITE}, MEM_ADDRESS); end
  endtask

  task automatic test_zero_wait();
    logic [BW-1:0] blk;
    blk = 128'h77777777_66666666_55555555_44444444;
    mem_lat = 1;
    MEM_READDATA = blk;
    D_ADDRESS = 28'h0000040;
    D_READ = 1'b1;
    tick();
    checks++; if (MEM_READ !== 1'b1 || D_BUSYWAIT !== 1'b1) begin failures++; $display("FAIL zw_grant: got rd=%0h busy=%0h want 1/1", MEM_READ, D_BUSYWAIT); end
    tick();
    checks++; if (D_BUSYWAIT !== 1'b0 || MEM_READ !== 1'b0) begin failures++; $display("FAIL zw_done: got busy=%0h rd=%0h want 0/0", D_BUSYWAIT, MEM_READ); end
    checks++; if (D_READDATA !== blk) begin failures++; $display("FAIL zw_data: got %0h want %0h", D_READDATA, blk); end
    D_READ = 1'b0;
    tick();
    checks++; if (D_BUSYWAIT !== 1'b0 || MEM_READ !== 1'b0) begin failures++; $display("FAIL zw_idle: got busy=%0h rd=%0h want 0/0", D_BUSYWAIT, MEM_READ); end
  endtask

  task automatic test_reset_mid_grant();
    mem_lat = 10;
    D_ADDRESS = 28'h0000050;
    D_WRITEDATA = 128'hABCD;
    D_WRITE = 1'b1;
    tick();
    checks++; if (MEM_WRITE !== 1'b1) begin failures++; $display("FAIL rmg_pre_write: got %0h want 1", MEM_WRITE); end
    #2;
    RESET = 1'b1;
    #1;
    checks++; if (MEM_WRITE !== 1'b0 || MEM_ADDRESS !== '0 || MEM_WRITEDATA !== '0) begin failures++; $display("FAIL rmg_strobe_drop: got wr=%0h addr=%0h wd=%0h want 0/0/0", MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA); end
    checks++; if (I_READDATA !== '0 || D_READDATA !== '0) begin failures++; $display("FAIL rmg_readdata: got %0h/%0h want 0/0", I_READDATA, D_READDATA); end
    D_WRITE = 1'b0;
    #1;
    checks++; if (D_BUSYWAIT !== 1'b0) begin failures++; $display("FAIL rmg_idle: got %0h want 0", D_BUSYWAIT); end
    tick();
    RESET = 1'b0;
    tick();
    checks++; if (MEM_WRITE !== 1'b0 || MEM_READ !== 1'b0) begin failures++; $display("FAIL rmg_after: got wr=%0h rd=%0h want 0/0", MEM_WRITE, MEM_READ); end
  endtask

  task automatic test_tie();
    logic [BW-1:0] blk;
    bit exp_d;
    int n;
    mem_lat = 2;
    I_ADDRESS = 28'h0000100;
    D_ADDRESS = 28'h0000200;
    D_WRITE = 1'b0;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      blk = {96'h0, 32'h1111_0000 + 32'(k)};
      MEM_READDATA = blk;
      I_READ = 1'b1;
      D_READ = 1'b1;
      tick();
      checks++; if (MEM_ADDRESS !== (exp_d ? D_ADDRESS : I_ADDRESS)) begin failures++; $display("FAIL tie%0d_winner: got addr %0h want %0h", k, MEM_ADDRESS, exp_d ? D_ADDRESS : I_ADDRESS); end
      checks++; if ((exp_d ? I_BUSYWAIT : D_BUSYWAIT) !== 1'b1) begin failures++; $display("FAIL tie%0d_loser_busy_grant: got 0 want 1", k); end
      wait_low(exp_d, 12, n);
      checks++; if (n !== 2) begin failures++; $display("FAIL tie%0d_latency: got %0d want 2", k, n); end
      checks++; if ((exp_d ? I_BUSYWAIT : D_BUSYWAIT) !== 1'b1) begin failures++; $display("FAIL tie%0d_loser_busy_done: got 0 want 1", k); end
      checks++; if ((exp_d ? D_READDATA : I_READDATA) !== blk) begin failures++; $display("FAIL tie%0d_data: got %0h want %0h", k, exp_d ? D_READDATA : I_READDATA, blk); end
      I_READ = 1'b0;
      D_READ = 1'b0;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_i_read_latency();
    test_d_write_wins();
    test_withdraw();
    test_zero_wait();
    test_reset_mid_grant();
    test_tie();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
